// File: rtl/memory_access.sv
// LEGv8 memory stage: turns one execute result into a single req/ack data-memory
// access, places store bytes on their lanes and extends load data for write-back.
module memory_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_extend,
  output logic        busy,
  output logic        done,
  output logic [63:0] read_data,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    strb_q, strb_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          fault_q, fault_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]  off;
  logic        misaligned;
  logic [7:0]  laneStrb;
  logic [63:0] laneData;
  logic [63:0] shifted;
  logic [63:0] loadExt;

  // Lane placement and alignment are derived from the live inputs so they can be
  // latched on the accepting edge; the stored copies stay stable through REQ.
  always_comb begin
    off        = alu_result[2:0];
    misaligned = 1'b0;
    laneStrb   = 8'h00;
    laneData   = store_data;
    case (size)
      2'd0: begin
        laneStrb = 8'b1 << off;
        laneData = {8{store_data[7:0]}};
      end
      2'd1: begin
        misaligned = off[0];
        laneStrb   = 8'b11 << off;
        laneData   = {4{store_data[15:0]}};
      end
      2'd2: begin
        misaligned = |off[1:0];
        laneStrb   = 8'hF << off;
        laneData   = {2{store_data[31:0]}};
      end
      default: begin
        misaligned = |off;
        laneStrb   = 8'hFF;
        laneData   = store_data;
      end
    endcase
  end

  always_comb begin
    shifted = dmem_rdata >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    loadExt = {{56{sext_q & shifted[7]}},  shifted[7:0]};
      2'd1:    loadExt = {{48{sext_q & shifted[15]}}, shifted[15:0]};
      2'd2:    loadExt = {{32{sext_q & shifted[31]}}, shifted[31:0]};
      default: loadExt = shifted;
    endcase
  end

  // Conflicting or misaligned requests never reach memory; they finish with a fault.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    size_d  = size_q;
    sext_d  = sext_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          addr_d  = alu_result;
          wdata_d = laneData;
          strb_d  = mem_write ? laneStrb : 8'h00;
          size_d  = size;
          sext_d  = sign_extend;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = '0;
          fault_d = (mem_read & mem_write) | misaligned;
          if ((mem_read & mem_write) | misaligned | ~(mem_read | mem_write)) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d = DONE;
          fault_d = 1'b0;
          if (rd_q) begin
            rdata_d = loadExt;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign fault      = (state_q == DONE) & fault_q;
  assign read_data  = rdata_q;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = (state_q == REQ) & wr_q;
  assign dmem_addr  = {addr_q[63:3], 3'b000};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = (state_q == REQ) ? strb_q : 8'h00;

endmodule

// File: tb/tb_memory_access.sv
// Randomized and directed bench for memory_access; expectations come from a
// byte-level model of lane placement, extension and req/ack timing.
module tb_memory_access;

  localparam int TOUT = 4;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_extend;
  logic        busy;
  logic        done;
  logic [63:0] read_data;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  int checkCount = 0;
  int failCount  = 0;
  logic [63:0] modelRead;

  memory_access #(.TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .valid(valid), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_extend(sign_extend), .busy(busy), .done(done),
    .read_data(read_data), .fault(fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelStrobe(input logic [63:0] addr, input logic [1:0] sz);
    logic [7:0] s = 8'h00;
    int o = int'(addr[2:0]);
    int n = 1 << sz;
    for (int j = 0; j < n; j++) begin
      if (o + j < 8) s[o + j] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [63:0] modelWdata(input logic [63:0] sd, input logic [1:0] sz);
    logic [63:0] w = '0;
    int n = 1 << sz;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] modelLoad(input logic [63:0] rdata, input logic [63:0] addr,
                                            input logic [1:0] sz, input logic sx);
    logic [63:0] v = '0;
    int o = int'(addr[2:0]);
    int n = 1 << sz;
    for (int j = 0; j < n; j++) begin
      if (o + j < 8) v[8*j +: 8] = rdata[8*(o + j) +: 8];
    end
    if (sx && n < 8 && v[8*n - 1]) begin
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  // One complete access: inputs scrambled while busy to prove they were latched.
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] sd, input logic [1:0] sz,
                               input logic sx, input logic rd, input logic wr,
                               input logic [63:0] rdata, input int ackDelay,
                               output int doneCyc, output logic gotFault, output logic [63:0] gotRead,
                               output logic [7:0] firstStrb, output logic [63:0] firstWdata,
                               output int reqCycles);
    int n = 1 << sz;
    logic expFault, expReq, ackWins, seen;
    int expCyc, expReqCycles, cyc;
    logic [63:0] expRead;
    expFault = (rd && wr) || ((addr % n) != 0);
    expReq   = !expFault && (rd || wr);
    ackWins  = expReq && ackDelay >= 0 && ackDelay < TOUT;
    expRead  = modelRead;
    if (!expReq) begin
      expCyc = 1; expReqCycles = 0;
    end else if (ackWins) begin
      expCyc = ackDelay + 2; expReqCycles = ackDelay + 1;
      if (rd) expRead = modelLoad(rdata, addr, sz, sx);
    end else begin
      expCyc = TOUT + 1; expReqCycles = TOUT; expFault = 1'b1;
    end
    doneCyc = -1; gotFault = 1'b0; gotRead = '0; firstStrb = '0; firstWdata = '0;
    reqCycles = 0; seen = 1'b0; cyc = 1;
    valid = 1'b1; alu_result = addr; store_data = sd; size = sz; sign_extend = sx;
    mem_read = rd; mem_write = wr; dmem_ack = 1'b0; dmem_rdata = rdata;
    @(posedge clk); @(negedge clk);
    while (!seen && cyc <= 20) begin
      valid = 1'($urandom_range(1)); alu_result = {$urandom, $urandom};
      store_data = {$urandom, $urandom}; size = 2'($urandom_range(3));
      mem_read = 1'($urandom_range(1)); mem_write = 1'($urandom_range(1));
      if (done) begin
        seen = 1'b1; doneCyc = cyc; gotFault = fault; gotRead = read_data;
        valid = 1'b0; dmem_ack = 1'b0;
      end else begin
        checkOutput("busyDuring", busy, 1);
        checkOutput("faultNoDone", fault, 0);
        if (dmem_req) begin
          reqCycles++;
          if (reqCycles == 1) begin
            firstStrb = dmem_wstrb; firstWdata = dmem_wdata;
          end
          checkOutput("reqAddr", dmem_addr, {addr[63:3], 3'b000});
          checkOutput("reqWe", dmem_we, wr);
          checkOutput("reqStrb", dmem_wstrb, wr ? modelStrobe(addr, sz) : 8'h00);
          if (wr) checkOutput("reqWdata", dmem_wdata, modelWdata(sd, sz));
          dmem_ack = (reqCycles - 1 == ackDelay);
        end else begin
          dmem_ack = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
    end
    dmem_ack = 1'b0; valid = 1'b0;
    if (!seen) checkOutput("doneSeen", 0, 1);
    checkOutput("doneCycle", 64'(doneCyc), 64'(expCyc));
    checkOutput("reqCycles", 64'(reqCycles), 64'(expReqCycles));
    checkOutput("fault", gotFault, expFault);
    checkOutput("readData", gotRead, expRead);
    modelRead = expRead;
    @(negedge clk);
    checkOutput("idleAfterDone", busy, 0);
    checkOutput("doneOnePulse", done, 0);
  endtask

  initial begin
    int dc, rq;
    logic f;
    logic [63:0] r, wd;
    logic [7:0] st;
    modelRead = '0;
    reset = 1'b0; valid = 1'b1; alu_result = 64'h1000; store_data = '0; mem_read = 1'b1;
    mem_write = 1'b0; size = 2'd3; sign_extend = 1'b0; dmem_ack = 1'b1; dmem_rdata = '1;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstFault", fault, 0);
    checkOutput("rstRead", read_data, 0);
    checkOutput("rstReq", dmem_req, 0);
    checkOutput("rstWe", dmem_we, 0);
    checkOutput("rstStrb", dmem_wstrb, 0);
    checkOutput("rstAddr", dmem_addr, 0);
    checkOutput("rstWdata", dmem_wdata, 0);
    reset = 1'b1; valid = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("postRstIdle", busy, 0);

    applyStimulus(64'h1000, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'h1122334455667788, 0, dc, f, r, st, wd, rq);
    checkOutput("ldurData", r, 64'h1122334455667788);
    checkOutput("ldurCycle", 64'(dc), 2);
    checkOutput("ldurStrb", st, 0);
    applyStimulus(64'h1008, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 0, dc, f, r, st, wd, rq);
    checkOutput("backToBack", r, 64'h0123456789ABCDEF);
    applyStimulus(64'h2004, 64'h0, 2'd2, 1'b1, 1'b1, 1'b0, 64'h8000000000000000, 1, dc, f, r, st, wd, rq);
    checkOutput("ldursw", r, 64'hFFFFFFFF80000000);
    applyStimulus(64'h2007, 64'h0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h8000000000000000, 0, dc, f, r, st, wd, rq);
    checkOutput("ldurb", r, 64'h80);
    applyStimulus(64'h3002, 64'hABCD, 2'd1, 1'b0, 1'b0, 1'b1, 64'h0, 3, dc, f, r, st, wd, rq);
    checkOutput("sturhStrb", st, 8'h0C);
    checkOutput("sturhLanes", wd[31:16], 16'hABCD);
    checkOutput("sturhCycle", 64'(dc), 5);
    applyStimulus(64'h4004, 64'h55, 2'd3, 1'b0, 1'b0, 1'b1, 64'h0, 0, dc, f, r, st, wd, rq);
    checkOutput("misalignFault", f, 1);
    checkOutput("misalignCycle", 64'(dc), 1);
    applyStimulus(64'h4000, 64'h55, 2'd3, 1'b0, 1'b1, 1'b1, 64'h0, 0, dc, f, r, st, wd, rq);
    checkOutput("bothFault", f, 1);
    applyStimulus(64'h5000, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'hDEAD, -1, dc, f, r, st, wd, rq);
    checkOutput("timeoutFault", f, 1);
    checkOutput("timeoutReqLen", 64'(rq), TOUT);
    checkOutput("timeoutHold", r, 64'h80);
    applyStimulus(64'h5000, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0, 64'hBEEF, TOUT - 1, dc, f, r, st, wd, rq);
    checkOutput("lateAckNoFault", f, 0);
    checkOutput("lateAckData", r, 64'hBEEF);

    // Reset in the second REQ cycle, then a stale ack once reset is released.
    valid = 1'b1; alu_result = 64'h6000; mem_read = 1'b1; mem_write = 1'b0; size = 2'd3;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    checkOutput("midReqStart", dmem_req, 1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("midRstReq", dmem_req, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstRead", read_data, 0);
    modelRead = '0;
    reset = 1'b1; dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("staleAckBusy", busy, 0);
    checkOutput("staleAckDone", done, 0);

    for (int t = 0; t < 150; t++) begin
      logic [1:0] sz;
      logic [63:0] a;
      logic rd, wr;
      int kind;
      sz = 2'($urandom_range(3));
      a = {$urandom, $urandom};
      if ($urandom_range(4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      kind = $urandom_range(19);
      rd = (kind == 0) || (kind >= 2 && kind <= 10);
      wr = (kind == 0) || (kind >= 11);
      applyStimulus(a, {$urandom, $urandom}, sz, 1'($urandom_range(1)), rd, wr,
                    {$urandom, $urandom}, $urandom_range(6) - 1, dc, f, r, st, wd, rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
